// File: rtl/dds_voice_scheduler.sv
// dds_voice_scheduler
// Time-multiplexes a single phase-accumulator adder across VOICES DDS voices.
// Each sample_tick starts one round-robin scan (one voice per cycle) and the
// top M bits of every updated phase are streamed out, tagged with the voice.
//
// Optional build macro: DDS_PHASE_SYNC_EN
//   defined   -> an accepted config write also zeroes that voice's phase,
//                giving a phase-coherent restart whenever a voice is retuned.
//   undefined -> config writes change only tuning and enable; phase is kept.

module dds_voice_scheduler #(
  parameter int VOICES = 4,
  parameter int N      = 23,
  parameter int M      = 14,
  parameter int TUNE   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_tick,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(VOICES)-1:0] cfg_voice,
  input  logic [TUNE-1:0]           cfg_tuning,
  input  logic                      cfg_enable,
  output logic                      busy,
  output logic                      phase_valid,
  output logic [$clog2(VOICES)-1:0] phase_voice,
  output logic [M-1:0]              phase_out,
  output logic                      overrun
);

  localparam int VW = $clog2(VOICES);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  // Slot being processed this cycle while scanning; parked at 0 when idle.
  logic [VW-1:0]   slot_q;

  // Per-voice configuration and accumulator storage.
  logic [TUNE-1:0] tuning_q [VOICES];
  logic [VOICES-1:0] enable_q;
  logic [N-1:0]    phase_q  [VOICES];

  // Shared accumulation path: one adder, operands muxed by the current slot.
  logic [N-1:0]    acc_cur;
  logic [N-1:0]    acc_inc;
  logic [N-1:0]    acc_sum;
  logic [N-1:0]    acc_new;

  logic            scanning;
  logic            last_slot;
  logic            cfg_accept;

  assign scanning   = (state_q == SCAN);
  assign last_slot  = (slot_q == VW'(VOICES - 1));
  assign cfg_accept = cfg_valid && cfg_ready;

  assign acc_cur = phase_q[slot_q];
  assign acc_inc = N'(tuning_q[slot_q]);
  assign acc_sum = acc_cur + acc_inc;
  assign acc_new = enable_q[slot_q] ? acc_sum : '0;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a tick in IDLE starts a scan, the last slot ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (last_slot) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM outputs: config writes are only taken while no scan is running.
  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:    cfg_ready = 1'b1;
      SCAN:    busy      = 1'b1;
      default: cfg_ready = 1'b0;
    endcase
  end

  // Slot counter: walks 0..VOICES-1 during a scan, wraps back to 0 at the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else if (scanning) begin
      slot_q <= slot_q + VW'(1);
    end else begin
      slot_q <= '0;
    end
  end

  // Tuning and enable storage, written by accepted config transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) begin
        tuning_q[i] <= '0;
      end
      enable_q <= '0;
    end else if (cfg_accept) begin
      tuning_q[cfg_voice] <= cfg_tuning;
      enable_q[cfg_voice] <= cfg_enable;
    end
  end

  // Phase storage: updated from the shared adder for the slot being scanned.
  // Writes and scans never overlap because config is only accepted in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) begin
        phase_q[i] <= '0;
      end
    end else begin
`ifdef DDS_PHASE_SYNC_EN
      if (cfg_accept) begin
        phase_q[cfg_voice] <= '0;
      end
`endif
      if (scanning) begin
        phase_q[slot_q] <= acc_new;
      end
    end
  end

  // Output stage: register the freshly computed phase one cycle after its slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_valid <= 1'b0;
      phase_voice <= '0;
      phase_out   <= '0;
    end else if (scanning) begin
      phase_valid <= 1'b1;
      phase_voice <= slot_q;
      phase_out   <= acc_new[N-1 -: M];
    end else begin
      phase_valid <= 1'b0;
      phase_voice <= '0;
      phase_out   <= '0;
    end
  end

  // Sticky overrun flag: a tick that lands while a scan is running is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (sample_tick && scanning) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dds_voice_scheduler.sv
// tb_dds_voice_scheduler
// Directed bench for dds_voice_scheduler. A round-level model predicts every
// voice's phase when a tick is taken, and a per-cycle compare process checks
// busy, cfg_ready, overrun and the tagged phase stream against it. Literal
// checks pin the model to hand-computed values.

module tb_dds_voice_scheduler;

  localparam int VOICES = 4;
  localparam int N      = 23;
  localparam int M      = 14;
  localparam int TUNE   = 16;
  localparam int VW     = $clog2(VOICES);

  logic            clk = 1'b0;
  logic            rst;
  logic            sample_tick;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [VW-1:0]   cfg_voice;
  logic [TUNE-1:0] cfg_tuning;
  logic            cfg_enable;
  logic            busy;
  logic            phase_valid;
  logic [VW-1:0]   phase_voice;
  logic [M-1:0]    phase_out;
  logic            overrun;

  int compared   = 0;
  int mismatched = 0;

  dds_voice_scheduler #(
    .VOICES(VOICES),
    .N(N),
    .M(M),
    .TUNE(TUNE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sample_tick(sample_tick),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_voice(cfg_voice),
    .cfg_tuning(cfg_tuning),
    .cfg_enable(cfg_enable),
    .busy(busy),
    .phase_valid(phase_valid),
    .phase_voice(phase_voice),
    .phase_out(phase_out),
    .overrun(overrun)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Round-level model state.
  longint modelPhase [VOICES];
  longint modelTune  [VOICES];
  bit     modelEn    [VOICES];
  int     expOut     [VOICES];
  int     lastOut    [VOICES];
  int     edgeNum    = 0;
  int     lastTick   = -100;
  bit     modelOverrun = 1'b0;
  bit     modelScanning;

  // Compare-process scratch.
  int cmpCycle;
  int cmpSlot;
  bit expBusy;
  bit expValid;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Model: edge k ends cycle k. A tick taken at edge T scans during cycles
  // T+1..T+VOICES, so the model is "scanning" at edges T+1..T+VOICES.
  always @(posedge clk) begin
    edgeNum++;
    if (rst) begin
      for (int i = 0; i < VOICES; i++) begin
        modelPhase[i] = 0;
        modelTune[i]  = 0;
        modelEn[i]    = 1'b0;
        expOut[i]     = 0;
      end
      lastTick     = -100;
      modelOverrun = 1'b0;
    end else begin
      modelScanning = (edgeNum >= lastTick + 1) && (edgeNum <= lastTick + VOICES);
      if (cfg_valid && !modelScanning) begin
        modelTune[cfg_voice] = longint'(cfg_tuning);
        modelEn[cfg_voice]   = cfg_enable;
`ifdef DDS_PHASE_SYNC_EN
        modelPhase[cfg_voice] = 0;
`endif
      end
      if (sample_tick) begin
        if (modelScanning) begin
          modelOverrun = 1'b1;
        end else begin
          lastTick = edgeNum;
          for (int k = 0; k < VOICES; k++) begin
            if (modelEn[k]) begin
              modelPhase[k] = (modelPhase[k] + modelTune[k]) % (longint'(1) << N);
            end else begin
              modelPhase[k] = 0;
            end
            expOut[k] = int'(modelPhase[k] >> (N - M));
          end
        end
      end
    end
  end

  // Per-cycle compare of every output against the model, mid-cycle.
  always @(negedge clk) begin
    if (edgeNum >= 1) begin
      cmpCycle = edgeNum + 1;
      expBusy  = (cmpCycle >= lastTick + 1) && (cmpCycle <= lastTick + VOICES);
      expValid = (cmpCycle >= lastTick + 2) && (cmpCycle <= lastTick + VOICES + 1);
      checkOutput("busy", 32'(busy), 32'(expBusy));
      checkOutput("cfg_ready", 32'(cfg_ready), 32'(!expBusy));
      checkOutput("overrun", 32'(overrun), 32'(modelOverrun));
      checkOutput("phase_valid", 32'(phase_valid), 32'(expValid));
      if (expValid) begin
        cmpSlot = cmpCycle - lastTick - 2;
        checkOutput("phase_voice", 32'(phase_voice), 32'(cmpSlot));
        checkOutput("phase_out", 32'(phase_out), 32'(expOut[cmpSlot]));
      end
      if (phase_valid) begin
        lastOut[phase_voice] = int'(phase_out);
      end
    end
  end

  // Drive one cycle of inputs starting just after a rising edge.
  task automatic applyStimulus(input bit tick, input bit cv, input int voice, input int tuning, input bit en);
    sample_tick = tick;
    cfg_valid   = cv;
    cfg_voice   = VW'(voice);
    cfg_tuning  = TUNE'(tuning);
    cfg_enable  = en;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    cfg_valid   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one tick and wait out the round; returns in the first IDLE cycle.
  task automatic tickRound();
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);
    idle(VOICES);
  endtask

  // Config write that holds cfg_valid until the scheduler is ready.
  task automatic writeCfg(input int voice, input int tuning, input bit en, output int stalls);
    bit done;
    done   = 1'b0;
    stalls = 0;
    cfg_valid  = 1'b1;
    cfg_voice  = VW'(voice);
    cfg_tuning = TUNE'(tuning);
    cfg_enable = en;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (cfg_ready) begin
        done = 1'b1;
      end else begin
        stalls++;
      end
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL cfg_wait: got no cfg_ready within 50 cycles, expected ready");
    end
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
  endtask

  // Runaway guard so the bench always terminates.
  initial begin
    #200000;
    mismatched++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Directed stimulus with literal expectations.
  initial begin
    int stalls;
    for (int i = 0; i < VOICES; i++) lastOut[i] = -1;
    rst = 1'b1;
    sample_tick = 1'b0;
    cfg_valid = 1'b0;
    cfg_voice = '0;
    cfg_tuning = '0;
    cfg_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset values");
    checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_phase_valid", 32'(phase_valid), 32'd0);
    checkOutput("rst_phase_voice", 32'(phase_voice), 32'd0);
    checkOutput("rst_phase_out", 32'(phase_out), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);

    $display("[TB] voice0 tuning 0x0100, two rounds");
    writeCfg(0, 'h0100, 1'b1, stalls);
    tickRound();
    idle(1);
    checkOutput("v0_round1", 32'(lastOut[0]), 32'd0);
    checkOutput("v3_round1", 32'(lastOut[3]), 32'd0);
    tickRound();
    idle(1);
    checkOutput("v0_round2", 32'(lastOut[0]), 32'd1);

    $display("[TB] voice2 tuning 0xFFFF, wrap after 129 rounds");
    writeCfg(2, 'hFFFF, 1'b1, stalls);
    repeat (128) tickRound();
    idle(1);
    checkOutput("v2_round128", 32'(lastOut[2]), 32'd16383);
    tickRound();
    idle(1);
    checkOutput("v2_round129", 32'(lastOut[2]), 32'd127);

    $display("[TB] latency and overrun");
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);
    checkOutput("lat_busy_T1", 32'(busy), 32'd1);
    checkOutput("lat_valid_T1", 32'(phase_valid), 32'd0);
    checkOutput("lat_ready_T1", 32'(cfg_ready), 32'd0);
    idle(2);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);
    checkOutput("overrun_set", 32'(overrun), 32'd1);
    idle(1);
    checkOutput("lat_busy_T5", 32'(busy), 32'd0);
    checkOutput("lat_voice_T5", 32'(phase_voice), 32'd3);
    checkOutput("lat_valid_T5", 32'(phase_valid), 32'd1);
    idle(1);

    $display("[TB] config stall during scan, then write with tick");
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);
    idle(1);
    checkOutput("stall_ready_T2", 32'(cfg_ready), 32'd0);
    writeCfg(1, 'h0200, 1'b1, stalls);
    checkOutput("stall_cycles", 32'(stalls), 32'd3);
    applyStimulus(1'b1, 1'b1, 3, 'h4000, 1'b1);
    idle(VOICES + 1);
    checkOutput("same_cycle_v3", 32'(lastOut[3]), 32'd32);
    checkOutput("same_cycle_v1", 32'(lastOut[1]), 32'd1);

    $display("[TB] reset mid-round");
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_ready", 32'(cfg_ready), 32'd1);
    checkOutput("mid_rst_valid", 32'(phase_valid), 32'd0);
    checkOutput("mid_rst_voice", 32'(phase_voice), 32'd0);
    checkOutput("mid_rst_out", 32'(phase_out), 32'd0);
    checkOutput("mid_rst_overrun", 32'(overrun), 32'd0);
    idle(6);
    writeCfg(2, 'hFFFF, 1'b1, stalls);
    tickRound();
    idle(1);
    checkOutput("post_rst_v2", 32'(lastOut[2]), 32'd127);

    $display("[TB] voice1 disable and re-enable");
    writeCfg(1, 'h0200, 1'b1, stalls);
    repeat (3) tickRound();
    idle(1);
    checkOutput("v1_three_rounds", 32'(lastOut[1]), 32'd3);
    writeCfg(1, 'h0200, 1'b0, stalls);
    tickRound();
    idle(1);
    checkOutput("v1_disabled", 32'(lastOut[1]), 32'd0);
    writeCfg(1, 'h0200, 1'b1, stalls);
    tickRound();
    idle(1);
    checkOutput("v1_reenabled", 32'(lastOut[1]), 32'd1);

    $display("[TB] retune behaviour");
    pulseReset();
    writeCfg(0, 'h0100, 1'b1, stalls);
    repeat (10) tickRound();
    idle(1);
    checkOutput("retune_before", 32'(lastOut[0]), 32'd5);
    writeCfg(0, 'h0100, 1'b1, stalls);
    tickRound();
    idle(1);
`ifdef DDS_PHASE_SYNC_EN
    checkOutput("retune_after", 32'(lastOut[0]), 32'd0);
`else
    checkOutput("retune_after", 32'(lastOut[0]), 32'd5);
`endif

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
